hazard_stall_ctrl: RTL

// - ID-stage hazard/stall controller for the 5-stage MIPS pipeline; sits beside the forwarding unit and

---
 rtl/hazard_stall_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard/stall controller: load-use, branch-operand-not-ready and MDU-busy stalls.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
module hazard_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_rs,
  input  logic [4:0]       IFID_rt,
  input  logic             UseRsD,
  input  logic             UseRtD,
  input  logic             BranchD,
  input  logic             StoreD,
  input  logic             MduOpD,
  input  logic             BranchTakenD,
  input  logic [4:0]       IDEX_WA,
  input  logic             RegWriteE,
  input  logic [1:0]       MemtoRegE,
  input  logic [4:0]       EXMEM_WA,
  input  logic [1:0]       MemtoRegM,
  input  logic             MduBusy,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             FlushD,
  output logic [CNT_W-1:0] StallCyc,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] hold_cnt_q, hold_cnt_d;
  logic       blank_q;

  logic load_e_s, load_m_s;
  logic rs_e_s, rt_e_s, m_e_s, m_m_s;
  logic luse_s, br_e_s, br_le_s, br_lm_s, mdu_s;
  logic need1_s, need2_s, block_s, stall_s, flush_d_s;

  // Hazard detection, stall/flush generation and FSM next state
  always_comb begin
    load_e_s   = (MemtoRegE == 2'd1);
    load_m_s   = (MemtoRegM == 2'd1);
    rs_e_s     = UseRsD && (IDEX_WA == IFID_rs);
    rt_e_s     = UseRtD && (IDEX_WA == IFID_rt);
    m_e_s      = (IDEX_WA != 5'd0) && (rs_e_s || rt_e_s);
    m_m_s      = (EXMEM_WA != 5'd0) &&
                 ((UseRsD && (EXMEM_WA == IFID_rs)) || (UseRtD && (EXMEM_WA == IFID_rt)));
    // store data (rt of sw) is forwarded from MEM, so it alone never load-use stalls
    luse_s     = load_e_s && (IDEX_WA != 5'd0) && (rs_e_s || (rt_e_s && !StoreD));
    br_e_s     = BranchD && RegWriteE && m_e_s && !load_e_s;
    br_le_s    = BranchD && load_e_s && m_e_s;
    br_lm_s    = BranchD && load_m_s && m_m_s;
    mdu_s      = MduOpD && MduBusy;
    need2_s    = br_le_s;
    need1_s    = br_e_s || br_lm_s || luse_s;
    block_s    = reset || blank_q;
    stall_s    = 1'b0;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      RUN: begin
        if (!block_s) begin
          stall_s = need2_s || need1_s || mdu_s;
          if (need2_s) begin
            state_d    = HOLD;
            hold_cnt_d = 2'd1;
          end else begin
            state_d    = RUN;
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      HOLD: begin
        stall_s    = !block_s;
        hold_cnt_d = hold_cnt_q - 2'd1;
        if (hold_cnt_q <= 2'd1) begin
          state_d = RUN;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        stall_s    = 1'b0;
        state_d    = RUN;
        hold_cnt_d = 2'd0;
      end
    endcase
    flush_d_s = BranchTakenD && !stall_s && !block_s;
  end

  assign StallF = stall_s;
  assign StallD = stall_s;
  assign FlushE = stall_s;
  assign FlushD = flush_d_s;

  // FSM state, hold counter and post-reset blanking flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      hold_cnt_q <= 2'd0;
      blank_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      blank_q    <= 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cyc_q, flush_cnt_q;

  // Wrapping performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cyc_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cyc_q <= stall_cyc_q + {{(CNT_W-1){1'b0}}, stall_s};
      flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, flush_d_s};
    end
  end

  assign StallCyc = stall_cyc_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCyc = {CNT_W{1'b0}};
  assign FlushCnt = {CNT_W{1'b0}};
`endif

endmodule
